blinky_soc_top: RTL and testbench



---
 rtl/blinky_soc_top.sv | 128 ++++++++++++
 tb/tb_blinky_soc_top.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/blinky_soc_top.sv
// Blinky SoC: 8-entry ROM accumulator sequencer driving a PORTB/DDRB/PINB GPIO port.
// Optional debug outputs dbg_pc/dbg_busy are present only when DEBUG_PC_EN is defined.
module blinky_soc_top #(
  parameter int unsigned DELAY_CYCLES = 100000,
  parameter logic [7:0]  LED_MASK     = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gpio_pin_in,
  output logic [7:0] gpio_pin_out,
  output logic [7:0] gpio_pin_dir
`ifdef DEBUG_PC_EN
  ,
  output logic [2:0] dbg_pc,
  output logic       dbg_busy
`endif
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDI   = 4'd1;
  localparam logic [3:0] OP_OUT   = 4'd2;
  localparam logic [3:0] OP_IN    = 4'd3;
  localparam logic [3:0] OP_XORI  = 4'd4;
  localparam logic [3:0] OP_ANDI  = 4'd5;
  localparam logic [3:0] OP_ORI   = 4'd6;
  localparam logic [3:0] OP_DELAY = 4'd7;
  localparam logic [3:0] OP_JMP   = 4'd8;

  localparam logic [31:0] DLY_LOAD = 32'(DELAY_CYCLES - 1);

  logic [2:0]  pc_q, pc_d, pc_inc;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  portb_q, portb_d;
  logic [7:0]  ddrb_q, ddrb_d;
  logic [7:0]  pinb_q;
  logic [31:0] dly_cnt_q, dly_cnt_d;
  logic        busy_q, busy_d;
  logic [11:0] instr;
  logic [3:0]  op;
  logic [7:0]  imm;

  always_comb begin
    instr = {OP_NOP, 8'h00};
    case (pc_q)
      3'd0: instr = {OP_LDI, LED_MASK};
      3'd1: instr = {OP_OUT, 8'h01};
      3'd2: instr = {OP_LDI, 8'h00};
      3'd3: instr = {OP_OUT, 8'h00};
      3'd4: instr = {OP_DELAY, 8'h00};
      3'd5: instr = {OP_XORI, LED_MASK};
      3'd6: instr = {OP_OUT, 8'h00};
      3'd7: instr = {OP_JMP, 8'h04};
      default: instr = {OP_NOP, 8'h00};
    endcase
  end

  assign op     = instr[11:8];
  assign imm    = instr[7:0];
  assign pc_inc = pc_q + 3'd1;

  always_comb begin
    pc_d      = pc_q;
    acc_d     = acc_q;
    portb_d   = portb_q;
    ddrb_d    = ddrb_q;
    dly_cnt_d = dly_cnt_q;
    busy_d    = busy_q;
    if (busy_q) begin
      // Stalled on DELAY: the clock that drains the counter also retires it.
      dly_cnt_d = dly_cnt_q - 32'd1;
      if (dly_cnt_q == 32'd1) begin
        busy_d = 1'b0;
        pc_d   = pc_inc;
      end
    end else begin
      pc_d = pc_inc;
      case (op)
        OP_LDI:  acc_d = imm;
        OP_OUT: begin
          if (imm[1:0] == 2'd0) portb_d = acc_q;
          if (imm[1:0] == 2'd1) ddrb_d  = acc_q;
        end
        OP_IN:   acc_d = pinb_q;
        OP_XORI: acc_d = acc_q ^ imm;
        OP_ANDI: acc_d = acc_q & imm;
        OP_ORI:  acc_d = acc_q | imm;
        OP_DELAY: begin
          if (DELAY_CYCLES > 1) begin
            pc_d      = pc_q;
            dly_cnt_d = DLY_LOAD;
            busy_d    = 1'b1;
          end
        end
        OP_JMP:  pc_d = imm[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= 3'd0;
      acc_q     <= 8'h00;
      portb_q   <= 8'h00;
      ddrb_q    <= 8'h00;
      pinb_q    <= 8'h00;
      dly_cnt_q <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      portb_q   <= portb_d;
      ddrb_q    <= ddrb_d;
      pinb_q    <= gpio_pin_in;
      dly_cnt_q <= dly_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign gpio_pin_out = portb_q;
  assign gpio_pin_dir = ddrb_q;

`ifdef DEBUG_PC_EN
  assign dbg_pc   = pc_q;
  assign dbg_busy = busy_q;
`endif

endmodule

// File: tb/tb_blinky_soc_top.sv
// Bench for blinky_soc_top: a long-delay and a single-cycle-delay instance run side by side.
`timescale 1ns/1ps
module tb_blinky_soc_top;

  logic       clk;
  logic       rst_n;
  logic [7:0] gpio_pin_in;
  logic [7:0] out_a, dir_a, out_b, dir_b;
`ifdef DEBUG_PC_EN
  logic [2:0] dbg_pc_a, dbg_pc_b;
  logic       dbg_busy_a, dbg_busy_b;
`endif

  blinky_soc_top #(.DELAY_CYCLES(20), .LED_MASK(8'h20)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .gpio_pin_in  (gpio_pin_in),
    .gpio_pin_out (out_a),
    .gpio_pin_dir (dir_a)
`ifdef DEBUG_PC_EN
    ,
    .dbg_pc       (dbg_pc_a),
    .dbg_busy     (dbg_busy_a)
`endif
  );

  blinky_soc_top #(.DELAY_CYCLES(1), .LED_MASK(8'h20)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .gpio_pin_in  (gpio_pin_in),
    .gpio_pin_out (out_b),
    .gpio_pin_dir (dir_b)
`ifdef DEBUG_PC_EN
    ,
    .dbg_pc       (dbg_pc_b),
    .dbg_busy     (dbg_busy_b)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [7:0] dir;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cur;
  vec_t tbl[15];
  vec_t sb[$];
  vec_t e;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cur);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_a"}, out_a, 8'h00);
    chk({tag, "_dir_a"}, dir_a, 8'h00);
    chk({tag, "_out_b"}, out_b, 8'h00);
    chk({tag, "_dir_b"}, dir_b, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    cur++;
    #2;
    case ($urandom_range(0, 2))
      0: gpio_pin_in = 8'h00;
      1: gpio_pin_in = 8'hFF;
      default: gpio_pin_in = 8'hA5;
    endcase
  endtask

  initial begin
    // A: D=20 -> first toggle edge 26, period 23. B: D=1 -> first toggle edge 7, period 4.
    tbl[0]  = '{1,  8'h00, 8'h00, 8'h00};
    tbl[1]  = '{2,  8'h00, 8'h00, 8'h20};
    tbl[2]  = '{4,  8'h00, 8'h00, 8'h20};
    tbl[3]  = '{6,  8'h00, 8'h00, 8'h20};
    tbl[4]  = '{7,  8'h00, 8'h20, 8'h20};
    tbl[5]  = '{10, 8'h00, 8'h20, 8'h20};
    tbl[6]  = '{11, 8'h00, 8'h00, 8'h20};
    tbl[7]  = '{13, 8'h00, 8'h00, 8'h20};
    tbl[8]  = '{15, 8'h00, 8'h20, 8'h20};
    tbl[9]  = '{25, 8'h00, 8'h20, 8'h20};
    tbl[10] = '{26, 8'h20, 8'h20, 8'h20};
    tbl[11] = '{48, 8'h20, 8'h20, 8'h20};
    tbl[12] = '{49, 8'h00, 8'h20, 8'h20};
    tbl[13] = '{72, 8'h20, 8'h20, 8'h20};
    tbl[14] = '{95, 8'h00, 8'h20, 8'h20};

    rst_n       = 1'b0;
    gpio_pin_in = 8'h00;
    cur         = 0;
    repeat (10) begin
      @(negedge clk);
      gpio_pin_in = ~gpio_pin_in;
    end
    chk_all_zero("reset_hold");

    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      rst_n = 1'b1;
      cur   = 0;
      for (int i = 0; i < 15; i++) begin
        while (cur < tbl[i].edge_n) step();
        sb.push_back(tbl[i]);
        #1;
        e = sb.pop_front();
        chk("out_a", out_a, e.out_a);
        chk("out_b", out_b, e.out_b);
        chk("dir_a", dir_a, e.dir);
        chk("dir_b", dir_b, e.dir);
      end
      if (pass == 0) begin
        // Edge 120 is inside A's delay (edges 120..139), LED on for both instances.
        while (cur < 120) step();
        #1;
        chk("pre_rst_out_a", out_a, 8'h20);
        chk("pre_rst_out_b", out_b, 8'h20);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_delay_rst");
        repeat (5) @(negedge clk);
        chk_all_zero("rst_held");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
